// File: rtl/acappella_pkg.sv
// Shared constants, client indices and arbiter state encoding for the SDRAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package acappella_pkg;

   localparam int N_CLIENTS    = 5;
   localparam int SDRAM_ADDR_W = 23;
   localparam int SAMPLE_W     = 16;
   localparam int PTR_W        = $clog2(N_CLIENTS);

   localparam int CLI_LOAD   = 0;
   localparam int CLI_MIX    = 1;
   localparam int CLI_PITCH  = 2;
   localparam int CLI_RECORD = 3;
   localparam int CLI_PLAY   = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } arb_state_t;

   // One-hot to binary index; returns 0 for an all-zero vector
   function automatic logic [PTR_W-1:0] onehot_idx(input logic [N_CLIENTS-1:0] oh);
      logic [PTR_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_CLIENTS; i++) begin
         if (oh[i]) idx = PTR_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bundle of client request/response signals and the single SDRAMBus command port.
// Latency: n/a (wiring only).
// Backpressure: clients hold requests until their finished pulse; SDRAM paces via sdram_finished.
interface sdram_arbiter_if;
   import acappella_pkg::*;

   logic [N_CLIENTS-1:0]                   cli_read;
   logic [N_CLIENTS-1:0]                   cli_write;
   logic [N_CLIENTS-1:0][SDRAM_ADDR_W-1:0] cli_addr;
   logic [N_CLIENTS-1:0][SAMPLE_W-1:0]     cli_writedata;
   logic [SAMPLE_W-1:0]                    cli_readdata;
   logic [N_CLIENTS-1:0]                   cli_finished;
   logic [N_CLIENTS-1:0]                   grant;

   logic                                   sdram_read;
   logic                                   sdram_write;
   logic [SDRAM_ADDR_W-1:0]                sdram_addr;
   logic [SAMPLE_W-1:0]                    sdram_writedata;
   logic [SAMPLE_W-1:0]                    sdram_readdata;
   logic                                   sdram_finished;

   // Arbiter view
   modport master (
      input  cli_read, cli_write, cli_addr, cli_writedata,
      input  sdram_readdata, sdram_finished,
      output cli_readdata, cli_finished, grant,
      output sdram_read, sdram_write, sdram_addr, sdram_writedata
   );

   // Environment view: the clients plus SDRAMBus
   modport slave (
      output cli_read, cli_write, cli_addr, cli_writedata,
      output sdram_readdata, sdram_finished,
      input  cli_readdata, cli_finished, grant,
      input  sdram_read, sdram_write, sdram_addr, sdram_writedata
   );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr (wrapping) wins.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; valid low when no request is present.
module rr_picker
   import acappella_pkg::*;
#(
   parameter int N  = N_CLIENTS,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  winner,
   output logic          valid
);

   logic [PW:0] idx;

   // Walk N slots starting at ptr; the first requesting slot is granted
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int i = 0; i < N; i++) begin
         idx = {1'b0, ptr} + (PW+1)'(i);
         if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
         if (!valid && req[idx[PW-1:0]]) begin
            winner[idx[PW-1:0]] = 1'b1;
            valid               = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Grants one client at a time onto SDRAMBus; returns read data and a one-cycle finished pulse.
// Latency: command from T+1 after request; finished pulse one cycle after sdram_finished.
// Backpressure: requests held until finished; optional ARB_RT_PRIORITY_EN favours clients 3/4.
module sdram_arbiter
   import acappella_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   sdram_arbiter_if.master     bus
);

   arb_state_t                 state_q, state_d;
   logic [PTR_W-1:0]           ptr_q;
   logic [N_CLIENTS-1:0]       owner_q;
   logic                       op_wr_q;
   logic [SDRAM_ADDR_W-1:0]    addr_q;
   logic [SAMPLE_W-1:0]        wdata_q;
   logic [SAMPLE_W-1:0]        rdata_q;

   logic [N_CLIENTS-1:0]       req;
   logic [N_CLIENTS-1:0]       req_pick;
   logic [N_CLIENTS-1:0]       winner;
   logic                       win_vld;
   logic [PTR_W-1:0]           win_idx;
   logic [PTR_W-1:0]           ptr_nxt;
   logic [SDRAM_ADDR_W-1:0]    sel_addr;
   logic [SAMPLE_W-1:0]        sel_wdata;
   logic                       take;

   assign req = bus.cli_read | bus.cli_write;

`ifdef ARB_RT_PRIORITY_EN
   // Real-time clients (record/play) shut out the rest whenever either is asking
   always_comb begin
      req_pick = req;
      if (req[CLI_RECORD] || req[CLI_PLAY]) begin
         req_pick = '0;
         req_pick[CLI_RECORD] = req[CLI_RECORD];
         req_pick[CLI_PLAY]   = req[CLI_PLAY];
      end
   end
`else
   assign req_pick = req;
`endif

   rr_picker #(
      .N  (N_CLIENTS),
      .PW (PTR_W)
   ) u_picker (
      .req    (req_pick),
      .ptr    (ptr_q),
      .winner (winner),
      .valid  (win_vld)
   );

   assign win_idx = onehot_idx(winner);
   assign ptr_nxt = (win_idx == PTR_W'(N_CLIENTS - 1)) ? '0 : win_idx + 1'b1;
   assign take    = (state_q == ST_IDLE) && win_vld;

   // Select the winner's address and write data for latching
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < N_CLIENTS; i++) begin
         if (winner[i]) begin
            sel_addr  = bus.cli_addr[i];
            sel_wdata = bus.cli_writedata[i];
         end
      end
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state: one transaction in flight, one DONE cycle for the client to drop its request
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (win_vld) state_d = ST_ISSUE;
         ST_ISSUE: if (bus.sdram_finished) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Latch the granted transaction, advance the pointer, capture read data
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         ptr_q   <= '0;
         owner_q <= '0;
         op_wr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (take) begin
            ptr_q   <= ptr_nxt;
            owner_q <= winner;
            op_wr_q <= |(bus.cli_write & winner);
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
         end
         if (state_q == ST_ISSUE && bus.sdram_finished && !op_wr_q) begin
            rdata_q <= bus.sdram_readdata;
         end
      end
   end

   // Outputs decoded from registers only, so nothing from cli_* reaches sdram_* combinationally
   always_comb begin
      bus.grant           = (state_q == ST_ISSUE) ? owner_q : '0;
      bus.cli_finished    = (state_q == ST_DONE)  ? owner_q : '0;
      bus.sdram_read      = (state_q == ST_ISSUE) && !op_wr_q;
      bus.sdram_write     = (state_q == ST_ISSUE) &&  op_wr_q;
      bus.sdram_addr      = addr_q;
      bus.sdram_writedata = wdata_q;
      bus.cli_readdata    = rdata_q;
   end

endmodule
